temporizador_bcd: RTL and testbench

BCD countdown timer for the irrigation controller. It loads the two-digit duration (tens/units BCD) produced by the state-to-duration mapping stage and counts it down to 00 at one step per second. It reports the remaining time for display and pulses `done` so the irrigation state machine can advance to its next state.

---
 rtl/temporizador_bcd.sv | 109 ++++++++++
 tb/tb_temporizador_bcd.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/temporizador_bcd.sv
// Two-digit BCD countdown timer: loads a tens/units duration and decrements it once per second.
// Optional 7-segment outputs hex_dez/hex_uni are built only when TEMPORIZADOR_SEG_EN is defined.
module temporizador_bcd #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       pause,
  input  logic [3:0] dez_in,
  input  logic [3:0] uni_in,
  output logic [3:0] dez_out,
  output logic [3:0] uni_out,
  output logic       running,
`ifdef TEMPORIZADOR_SEG_EN
  output logic [6:0] hex_dez,
  output logic [6:0] hex_uni,
`endif
  output logic       done
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [3:0]    dez_ld;
  logic [3:0]    uni_ld;

  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  assign dez_ld  = clamp9(dez_in);
  assign uni_ld  = clamp9(uni_in);
  assign running = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      presc   <= '0;
      dez_out <= 4'd0;
      uni_out <= 4'd0;
      done    <= 1'b0;
    end else if (load) begin
      // A load overrides any tick due this cycle, so the old count never reports done.
      dez_out <= dez_ld;
      uni_out <= uni_ld;
      presc   <= '0;
      if (dez_ld == 4'd0 && uni_ld == 4'd0) begin
        state <= IDLE;
        done  <= 1'b1;
      end else begin
        state <= RUN;
        done  <= 1'b0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: presc <= '0;
        RUN: begin
          if (!pause) begin
            if (presc == PRESC_LAST) begin
              presc <= '0;
              if (uni_out != 4'd0) begin
                uni_out <= uni_out - 4'd1;
              end else begin
                uni_out <= 4'd9;
                dez_out <= dez_out - 4'd1;
              end
              if (dez_out == 4'd0 && uni_out == 4'd1) begin
                state <= IDLE;
                done  <= 1'b1;
              end
            end else begin
              presc <= presc + PW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TEMPORIZADOR_SEG_EN
  // Active-low segments, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  assign hex_dez = seg7(dez_out);
  assign hex_uni = seg7(uni_out);
`endif

endmodule

// File: tb/tb_temporizador_bcd.sv
// Scoreboard bench for temporizador_bcd: an integer-seconds model predicts every cycle,
// a forked monitor compares DUT outputs, and directed checks cover the timing scenarios.
module tb_temporizador_bcd;

  localparam int TPS = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic       pause = 1'b0;
  logic [3:0] dez_in = 4'd0;
  logic [3:0] uni_in = 4'd0;
  logic [3:0] dez_out;
  logic [3:0] uni_out;
  logic       running;
  logic       done;
`ifdef TEMPORIZADOR_SEG_EN
  logic [6:0] hex_dez;
  logic [6:0] hex_uni;
`endif

  temporizador_bcd #(.TICKS_PER_SEC(TPS)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .pause(pause),
    .dez_in(dez_in), .uni_in(uni_in),
    .dez_out(dez_out), .uni_out(uni_out), .running(running),
`ifdef TEMPORIZADOR_SEG_EN
    .hex_dez(hex_dez), .hex_uni(hex_uni),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] d;
    logic [3:0] u;
    logic       r;
    logic       dn;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Reference: remaining time in whole seconds plus unpaused cycles since the last step.
  int m_rem = 0;
  int m_phase = 0;
  bit m_run = 0;
  bit m_done = 0;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_step(input logic l, input logic p, input logic [3:0] d, input logic [3:0] u);
    int dc, uc;
    m_done = 0;
    if (!rst_n) begin
      m_rem = 0; m_phase = 0; m_run = 0;
    end else if (l) begin
      dc = (d > 9) ? 9 : int'(d);
      uc = (u > 9) ? 9 : int'(u);
      m_rem = 10 * dc + uc;
      m_phase = 0;
      m_run = (m_rem != 0);
      m_done = (m_rem == 0);
    end else if (m_run && !p) begin
      m_phase++;
      if (m_phase == TPS) begin
        m_phase = 0;
        m_rem--;
        if (m_rem == 0) begin
          m_run = 0;
          m_done = 1;
        end
      end
    end
  endtask

  // Drive one cycle's inputs at a falling edge, predict the post-edge outputs, return at the next falling edge.
  task automatic cyc(input logic l, input logic p, input logic [3:0] d, input logic [3:0] u);
    exp_t e;
    load = l; pause = p; dez_in = d; uni_in = u;
    model_step(l, p, d, u);
    e.d = 4'(m_rem / 10);
    e.u = 4'(m_rem % 10);
    e.r = m_run;
    e.dn = m_done;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'd0, 4'd0);
  endtask

  task automatic chk_out(input string name, input int d, input int u, input int r, input int dn);
    chk({name, ".dez"}, int'(dez_out), d);
    chk({name, ".uni"}, int'(uni_out), u);
    chk({name, ".running"}, int'(running), r);
    chk({name, ".done"}, int'(done), dn);
  endtask

  initial begin
    int first, pulses;
    exp_t e;

    fork
      forever begin
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
          e = q.pop_front();
          checks++;
          if (dez_out !== e.d || uni_out !== e.u || running !== e.r || done !== e.dn) begin
            failures++;
            $display("FAIL scoreboard: got %0d/%0d run=%0b done=%0b expected %0d/%0d run=%0b done=%0b at %0t",
                     dez_out, uni_out, running, done, e.d, e.u, e.r, e.dn, $time);
          end
        end
      end
    join_none

    @(negedge clk);
    @(negedge clk);
    chk_out("reset", 0, 0, 0, 0);
    rst_n = 1'b1;

    // 30 s countdown
    cyc(1'b1, 1'b0, 4'd3, 4'd0);
    idle(4);
    chk_out("first_tick", 2, 9, 1, 0);
    idle(115);
    chk_out("pre_expiry", 0, 1, 1, 0);
    idle(1);
    chk_out("expiry_30", 0, 0, 0, 1);
    idle(1);
    chk_out("after_expiry", 0, 0, 0, 0);

    // 5 s with 10 paused cycles after cycle 6
    cyc(1'b1, 1'b0, 4'd0, 4'd5);
    first = -1; pulses = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc(1'b0, (i >= 7 && i <= 16), 4'd0, 4'd0);
      if (done) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    chk("pause_done_cycle", first, 30);
    chk("pause_done_pulses", pulses, 1);

    // reload coinciding with a tick
    cyc(1'b1, 1'b0, 4'd1, 4'd5);
    idle(7);
    chk_out("pre_reload", 1, 4, 1, 0);
    cyc(1'b1, 1'b0, 4'd0, 4'd5);
    chk_out("reload", 0, 5, 1, 0);
    idle(3);
    chk_out("reload_hold", 0, 5, 1, 0);
    idle(1);
    chk_out("reload_tick", 0, 4, 1, 0);
    first = -1; pulses = 0;
    for (int i = 5; i <= 26; i++) begin
      idle(1);
      if (done) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    chk("reload_done_cycle", first, 20);
    chk("reload_done_pulses", pulses, 1);

    // zero load, repeated zero load, clamping
    cyc(1'b1, 1'b0, 4'd0, 4'd0);
    chk_out("zero_load", 0, 0, 0, 1);
    cyc(1'b1, 1'b0, 4'd0, 4'd0);
    chk_out("zero_load_again", 0, 0, 0, 1);
    idle(1);
    chk_out("zero_load_after", 0, 0, 0, 0);
    cyc(1'b1, 1'b0, 4'd12, 4'd15);
    chk_out("clamp", 9, 9, 1, 0);

    // asynchronous reset mid-count at 1/0
    cyc(1'b1, 1'b0, 4'd1, 4'd1);
    idle(4);
    chk_out("at_10", 1, 0, 1, 0);
`ifdef TEMPORIZADOR_SEG_EN
    chk("hex_dez", int'(hex_dez), 7'b1111001);
    chk("hex_uni", int'(hex_uni), 7'b1000000);
`endif
    idle(2);
    rst_n = 1'b0;
    model_step(1'b0, 1'b0, 4'd0, 4'd0);
    #1;
    chk_out("async_reset", 0, 0, 0, 0);
    @(negedge clk);
    cyc(1'b0, 1'b0, 4'd0, 4'd0);
    rst_n = 1'b1;
    idle(10);
    chk_out("post_reset_idle", 0, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic l, p;
      logic [3:0] d, u;
      l = ($urandom_range(0, 29) == 0);
      p = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      u = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) begin
        d = 4'd0;
        u = 4'($urandom_range(0, 2));
      end
      cyc(l, p, d, u);
    end
    idle(3);
    @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
